// File: rtl/vga_pkg.sv
// Shared VGA constants and pixel-feeder state encoding, also used by the timing
// controller and the SDRAM read-address generator.
package vga_pkg;

  localparam int          H_VALID     = 640;
  localparam int          V_VALID     = 480;
  localparam int          FRAME_PIX   = H_VALID * V_VALID;
  localparam int          FILL_LEVEL  = 256;
  localparam logic [15:0] BLANK_COLOR = 16'h0000;
  localparam int          CNT_W       = 19;
  localparam int          FCNT_W      = 10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    STREAM  = 3'd2,
    WAIT_VS = 3'd3,
    SKIP    = 3'd4
  } feed_state_e;

endpackage

// File: rtl/vga_edge_det.sv
// Rising-edge detector for the controller vsync pulse.
module vga_edge_det (
  input  logic vga_clk,
  input  logic sys_rst_n,
  input  logic sig,
  output logic rise
);

  logic sig_d;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) sig_d <= 1'b0;
    else            sig_d <= sig;
  end

  assign rise = sig & ~sig_d;

endmodule

// File: rtl/vga_pix_feeder.sv
// Pixel source ahead of the VGA timing controller: paces FIFO reads from
// pix_data_req, blanks on underflow and keeps every frame pixel-aligned.
//
// state   | meaning
// IDLE    | waiting for a vsync edge
// FILL    | frame started, waiting for the FIFO to reach the fill level
// STREAM  | one FIFO read per pixel request, counting pixels
// WAIT_VS | full frame delivered, waiting for the next vsync
// SKIP    | frame missed its fill level, output blanked until vsync
module vga_pix_feeder #(
  parameter int          H_VALID     = vga_pkg::H_VALID,
  parameter int          V_VALID     = vga_pkg::V_VALID,
  parameter int          FILL_LEVEL  = vga_pkg::FILL_LEVEL,
  parameter logic [15:0] BLANK_COLOR = vga_pkg::BLANK_COLOR,
  parameter int          CNT_W       = vga_pkg::CNT_W,
  parameter int          FCNT_W      = vga_pkg::FCNT_W
) (
  input  logic              vga_clk,
  input  logic              sys_rst_n,
  input  logic              vsync,
  input  logic              pix_data_req,
  input  logic [15:0]       fifo_rd_data,
  input  logic [FCNT_W-1:0] fifo_rd_cnt,
  input  logic              fifo_empty,
  input  logic              err_clr,
  output logic              fifo_rd_en,
  output logic [15:0]       pix_data,
  output logic              frame_start,
  output logic              resync_req,
  output logic              underflow,
  output logic              frame_err,
  output logic              streaming
);

  import vga_pkg::*;

  localparam logic [CNT_W-1:0]  FRAME_CNT = CNT_W'(H_VALID * V_VALID);
  localparam logic [FCNT_W-1:0] FILL_CNT  = FCNT_W'(FILL_LEVEL);

  feed_state_e      state, state_nxt;
  logic [CNT_W-1:0] pix_cnt, pix_cnt_nxt;
  logic             bad, bad_nxt;
  logic             rd_en_d;
  logic             vs_rise;
  logic             fill_ok;
  logic             fs_nxt, rs_nxt, uf_set, fe_set;

  vga_edge_det u_vs_edge (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .sig       (vsync),
    .rise      (vs_rise)
  );

  assign fill_ok    = (fifo_rd_cnt >= FILL_CNT);
  assign fifo_rd_en = pix_data_req & ~fifo_empty & (state == STREAM);
  assign pix_data   = rd_en_d ? fifo_rd_data : BLANK_COLOR;

  always_comb begin
    state_nxt   = state;
    pix_cnt_nxt = pix_cnt;
    bad_nxt     = bad;
    fs_nxt      = 1'b0;
    rs_nxt      = 1'b0;
    uf_set      = 1'b0;
    fe_set      = 1'b0;
    case (state)
      IDLE: begin
        if (vs_rise) state_nxt = FILL;
      end
      FILL: begin
        if (vs_rise) begin
          state_nxt = FILL;
        end else if (pix_data_req && !fill_ok) begin
          uf_set    = 1'b1;
          state_nxt = SKIP;
        end else if (!pix_data_req && fill_ok) begin
          fs_nxt      = 1'b1;
          pix_cnt_nxt = '0;
          state_nxt   = STREAM;
        end
      end
      STREAM: begin
        if (pix_cnt == FRAME_CNT) begin
          if (bad) begin
            rs_nxt    = 1'b1;
            bad_nxt   = 1'b0;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT_VS;
          end
        end else if (vs_rise) begin
          fe_set    = 1'b1;
          rs_nxt    = 1'b1;
          bad_nxt   = 1'b0;
          state_nxt = IDLE;
        end else if (pix_data_req) begin
          // an empty-FIFO request still consumes its pixel slot
          pix_cnt_nxt = pix_cnt + 1'b1;
          if (fifo_empty) begin
            uf_set  = 1'b1;
            bad_nxt = 1'b1;
          end
        end
      end
      WAIT_VS: begin
        if (pix_data_req) fe_set = 1'b1;
        if (vs_rise) state_nxt = FILL;
      end
      SKIP: begin
        if (vs_rise) begin
          rs_nxt    = 1'b1;
          state_nxt = FILL;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      pix_cnt     <= '0;
      bad         <= 1'b0;
      rd_en_d     <= 1'b0;
      frame_start <= 1'b0;
      resync_req  <= 1'b0;
      underflow   <= 1'b0;
      frame_err   <= 1'b0;
      streaming   <= 1'b0;
    end else begin
      state       <= state_nxt;
      pix_cnt     <= pix_cnt_nxt;
      bad         <= bad_nxt;
      rd_en_d     <= fifo_rd_en;
      frame_start <= fs_nxt;
      resync_req  <= rs_nxt;
      underflow   <= uf_set | (underflow & ~err_clr);
      frame_err   <= fe_set | (frame_err & ~err_clr);
      streaming   <= (state_nxt == STREAM);
    end
  end

endmodule

// File: doc/vga_pix_feeder.md
Name: vga_pix_feeder

Overview:
- Pixel source stage directly upstream of the VGA timing controller, in the vga_clk domain.
- Turns the controller's pix_data_req into read strobes on the vga-side port of the SDRAM read FIFO (normal mode: data one cycle after rd_en).
- Presents pix_data aligned to the controller's rgb window.
- Enforces frame alignment by counting pixels per frame. Substitutes a blank colour on underflow and requests an upstream resync when a frame is corrupted.

Parameters:
- H_VALID, 640, active pixels per line
- V_VALID, 480, active lines per frame
- FRAME_PIX, H_VALID*V_VALID (307200), pixels per frame
- FILL_LEVEL, 256, FIFO words required before a frame may stream
- BLANK_COLOR, 16'h0000, RGB565 value output when no valid data
- CNT_W, 19, pixel counter width (must hold FRAME_PIX)
- FCNT_W, 10, fifo_rd_cnt width

Ports:
- vga_clk  in  1  pixel clock
- sys_rst_n  in  1  reset
- vsync  in  1  controller vsync, active-high pulse at frame start
- pix_data_req  in  1  controller pixel request, one cycle ahead of rgb window
- fifo_rd_data  in  16  FIFO read data, valid the cycle after fifo_rd_en
- fifo_rd_cnt  in  FCNT_W  FIFO words available
- fifo_empty  in  1  FIFO empty
- err_clr  in  1  clears sticky error flags
- fifo_rd_en  out  1  FIFO read strobe
- pix_data  out  16  pixel to controller
- frame_start  out  1  one-cycle pulse on accepted frame start
- resync_req  out  1  one-cycle pulse asking upstream to flush FIFO and restart from frame address 0
- underflow  out  1  sticky: a request hit an empty FIFO
- frame_err  out  1  sticky: frame pixel count mismatch
- streaming  out  1  high in STREAM state

Behaviour:
- Reset: sys_rst_n is asynchronous, active-low; the block is clocked by vga_clk.
- Reset values: state=IDLE, pix_cnt=0, rd_en_d=0, vsync_d=0, and fifo_rd_en, frame_start, resync_req, underflow, frame_err, streaming all 0. pix_data therefore shows BLANK_COLOR.
- Reset mid-frame:
  - The block returns to IDLE immediately.
  - No resync_req is issued on reset exit; upstream is reset by the same sys_rst_n.
- vs_rise = vsync & ~vsync_d (vsync_d is a registered copy of vsync).
- Read path:
  - fifo_rd_en = pix_data_req & ~fifo_empty & (state==STREAM), combinational.
  - rd_en_d is fifo_rd_en registered.
  - pix_data = rd_en_d ? fifo_rd_data : BLANK_COLOR, combinational.
  - Total latency: request at cycle t gives FIFO data on pix_data at t+1.
- States:
  - IDLE:
    - No reads.
    - On vs_rise, go to FILL.
  - FILL:
    - No reads.
    - If fifo_rd_cnt >= FILL_LEVEL while pix_data_req is low: frame_start pulses, pix_cnt clears, go to STREAM.
    - If pix_data_req rises while still below FILL_LEVEL: set underflow, go to SKIP. The frame is blanked.
    - If vs_rise occurs: stay in FILL.
  - STREAM:
    - Every cycle with pix_data_req=1, pix_cnt increments, whether or not the read happened.
    - pix_data_req=1 with fifo_empty=1: no read, underflow set, bad flag set. The pixel slot is consumed to keep alignment.
    - When pix_cnt reaches FRAME_PIX:
      - If bad=0, go to WAIT_VS.
      - If bad=1, pulse resync_req, clear bad, go to IDLE.
    - vs_rise before FRAME_PIX is reached: set frame_err, pulse resync_req, clear bad, go to IDLE (the vs_rise is consumed).
  - WAIT_VS:
    - No reads.
    - pix_data_req=1 here sets frame_err.
    - On vs_rise, go to FILL (back-to-back frames).
  - SKIP:
    - No reads; BLANK_COLOR is output.
    - On vs_rise, pulse resync_req and go to FILL.
- Sticky flags: underflow and frame_err clear only on err_clr. A set event in the same cycle as err_clr wins (the flag stays 1).
- pix_cnt saturates at FRAME_PIX and never wraps.
- streaming = (state==STREAM), registered decode.

Decomposition:
- Shared package vga_pkg:
  - timing constants H_VALID, V_VALID, FRAME_PIX, BLANK_COLOR
  - state encoding IDLE=0, FILL=1, STREAM=2, WAIT_VS=3, SKIP=4 (3 bits)
  - These are shared with the VGA timing controller and the SDRAM read-address generator.
- Optional sub-module vga_edge_det: vsync rising-edge detector.
- The rest is a single module.

Test Plan:
- Nominal: FIFO model preloaded with 307200 incrementing words, full 800x525 timing. Required: frame_start pulses once; pix_data equals word n on the cycle after the nth request; 307200 reads; no flags set; WAIT_VS is reached.
- Fill gate: fifo_rd_cnt held at 255 through the first request. Required: underflow=1, SKIP entered, zero reads, pix_data=16'h0000 all frame; resync_req pulses once at the next vs_rise.
- Mid-frame underflow: fifo_empty forced high for 3 requests at pixel 1000. Required: 3 BLANK pixels, underflow=1, pix_cnt still reaches 307200, then one resync_req and IDLE.
- Short frame: vsync pulsed after 1000 pixels. Required: frame_err=1, resync_req pulse, state IDLE, then FILL on the following vs_rise.
- err_clr: assert err_clr alone, then together with a new underflow event. Required: the flag clears in the first case and stays 1 in the second.
- Reset mid-STREAM at pixel 5000. Required: all outputs 0 or BLANK asynchronously; after release no reads until vs_rise plus a satisfied fill condition.
